shift_unit_seq: RTL and testbench
=================================

Name: shift_unit_seq

Overview:
- Multi-cycle iterative shifter that computes the same four operations as the combinational barrel shifter: logical left, logical right, arithmetic right and rotate right.
- Moves one bit per cycle under a start/done handshake.
- Sits in the MIPS execute stage as the low-area alternative to the barrel shifter and reuses its op encoding and result semantics.
- Results must match the barrel shifter bit-for-bit for every op/count pair.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- ADDR_WIDTH, 5, shift-count width; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only while ready=1.
- data_in  input  DATA_WIDTH  operand; captured on the accepting edge.
- shift_count  input  ADDR_WIDTH  shift amount 0..DATA_WIDTH-1; captured on the accepting edge.
- op  input  2  0=lo_l (SLL), 1=lo_r (SRL), 2=al_r (SRA), 3=ci_r (ROR); captured on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT or DONE.
- done  output  1  one-cycle pulse; data_out is valid from this cycle.
- data_out  output  DATA_WIDTH  result; holds its value until the next accepted start.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, ready=1, busy=0, done=0, data_out=0, remaining count=0, captured op=0.
  - Any in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 captures data_in into the working register, plus shift_count and op.
  - If shift_count==0, go to DONE.
  - Otherwise go to SHIFT with remaining=shift_count.
- SHIFT: at each edge, apply one 1-bit step of the captured op to the working register and decrement remaining; when remaining==1 before the step, go to DONE.
  - lo_l: shift left, zero fill.
  - lo_r: shift right, zero fill.
  - al_r: shift right, fill with the current MSB.
  - ci_r: rotate right, old bit0 becomes the MSB.
- DONE:
  - done=1 for exactly this cycle.
  - data_out equals the working register; it is driven from that register and is stable from the start of the DONE cycle.
  - Next edge goes to IDLE unconditionally.
- Latency: done is high in the cycle following edge E_max(count,0), where E0 is the accepting edge.
  - count=0: done is high during the cycle after E0.
  - count=N: done is high during the cycle after EN.
  - Throughput: one operation per count+2 cycles.
- start while busy (SHIFT or DONE) is ignored, with no queuing; inputs may change freely while busy.
- start held continuously: a new operation is accepted on the first IDLE edge after DONE.
- Count wrap: shift_count is unsigned; DATA_WIDTH-1 is the maximum, so no modulo handling is needed beyond the port width.
- Rotate by 0 and SRA by 0 return the operand unchanged.

Optional Feature:
- Macro: SHIFT_UNIT_STEP4_EN.
- Defined:
  - In SHIFT, if remaining>=4, apply a 4-bit step of the captured op and subtract 4; otherwise apply a 1-bit step.
  - DONE is entered when the step taken exhausts remaining.
  - Latency for count N becomes floor(N/4) + (N mod 4) SHIFT cycles.
  - Results are identical to the 1-bit-step build.
- Undefined: 1-bit steps only, with latency exactly as specified above.

Decomposition:
- Shared package shift_pkg:
  - Op encodings OP_LO_L=2'd0, OP_LO_R=2'd1, OP_AL_R=2'd2, OP_CI_R=2'd3; shared with barrel_shift_mips and its benches.
  - State encoding ST_IDLE, ST_SHIFT, ST_DONE.
  - Default DATA_WIDTH and ADDR_WIDTH constants.
- One combinational sub-module, shift_step:
  - Inputs: word, op, 1-bit vs 4-bit step select.
  - Output: stepped word.
  - Keeps the sequencer free of datapath detail.

Test Plan:
- data_in=0x12345678, count=4, op=lo_l -> done pulse in the cycle after E4; data_out=0x23456780; ready returns 1 one cycle later.
- data_in=0x12345678, count=3, op=lo_r -> data_out=0x02468ACF.
- data_in=0xF2345678, count=2, op=al_r -> data_out=0xFC8D159E (sign fill).
- data_in=0xF2345678, count=1, op=ci_r -> data_out=0x791A2B3C; data_in=0x80000001, count=31, ci_r -> 0x00000003.
- count=0 with each op on 0xA5A5A5A5 -> done in the cycle after E0; data_out=0xA5A5A5A5. Pulsing start during SHIFT changes nothing.
- Start count=20, deassert rst_n at E5 -> ready=1, busy=0, done=0, data_out=0 immediately; no done pulse follows. A new op after release completes normally. Rerun all cases with SHIFT_UNIT_STEP4_EN defined: identical results; count=20 gives done after E5.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the MIPS execute-stage shifters (barrel and iterative).
// Op codes must stay aligned with barrel_shift_mips and its benches.
package shift_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        OP_LO_L = 2'd0,
        OP_LO_R = 2'd1,
        OP_AL_R = 2'd2,
        OP_CI_R = 2'd3
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational step of the iterative shifter: moves the word by 1 or 4 bits
// according to the op, with the same fill rules as the barrel shifter.
module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  shift_op_e             i_op,
    input  logic                  i_step4,
    output logic [DATA_WIDTH-1:0] o_word
);

    always_comb begin
        o_word = i_word;
        if (i_step4) begin
            unique case (i_op)
                OP_LO_L: o_word = i_word << 4;
                OP_LO_R: o_word = i_word >> 4;
                OP_AL_R: o_word = $signed(i_word) >>> 4;
                OP_CI_R: o_word = {i_word[3:0], i_word[DATA_WIDTH-1:4]};
                default: o_word = i_word;
            endcase
        end else begin
            unique case (i_op)
                OP_LO_L: o_word = {i_word[DATA_WIDTH-2:0], 1'b0};
                OP_LO_R: o_word = {1'b0, i_word[DATA_WIDTH-1:1]};
                OP_AL_R: o_word = {i_word[DATA_WIDTH-1], i_word[DATA_WIDTH-1:1]};
                OP_CI_R: o_word = {i_word[0], i_word[DATA_WIDTH-1:1]};
                default: o_word = i_word;
            endcase
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative low-area shifter with start/done handshake; bit-exact with the barrel shifter.
// Define SHIFT_UNIT_STEP4_EN to take 4-bit steps while at least 4 positions remain.
//
// state    | meaning
// ST_IDLE  | ready, waiting for start
// ST_SHIFT | stepping the working register, remaining counts down
// ST_DONE  | one-cycle done pulse, data_out valid
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] shift_count,
    input  logic [1:0]            op,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out
);

    shift_state_e          r_state, w_state_nxt;
    shift_op_e             r_op, w_op_nxt;
    logic [DATA_WIDTH-1:0] r_work, w_work_nxt, w_stepped;
    logic [ADDR_WIDTH-1:0] r_remaining, w_remaining_nxt, w_step_size;
    logic                  w_step4;

`ifdef SHIFT_UNIT_STEP4_EN
    assign w_step4 = (r_remaining >= ADDR_WIDTH'(4));
`else
    assign w_step4 = 1'b0;
`endif
    assign w_step_size = w_step4 ? ADDR_WIDTH'(4) : ADDR_WIDTH'(1);

    shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .i_word  (r_work),
        .i_op    (r_op),
        .i_step4 (w_step4),
        .o_word  (w_stepped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_LO_L;
            r_work      <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_work      <= w_work_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_work_nxt      = r_work;
        w_remaining_nxt = r_remaining;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_op_nxt        = shift_op_e'(op);
                    w_work_nxt      = data_in;
                    w_remaining_nxt = shift_count;
                    w_state_nxt     = (shift_count == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_work_nxt      = w_stepped;
                w_remaining_nxt = r_remaining - w_step_size;
                if (r_remaining == w_step_size) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // All handshake outputs decode straight from the state register, so they are glitch-free.
    assign ready    = (r_state == ST_IDLE);
    assign busy     = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign done     = (r_state == ST_DONE);
    assign data_out = r_work;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed-vector bench for shift_unit_seq; latency expectations follow SHIFT_UNIT_STEP4_EN.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data_in = '0;
    logic [4:0]  shift_count = '0;
    logic [1:0]  op = '0;
    logic        ready, busy, done;
    logic [31:0] data_out;

    int errors = 0;
    int checks = 0;

    shift_unit_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .shift_count (shift_count),
        .op          (op),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .data_out    (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  count;
        logic [1:0]  opc;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic int exp_latency(input logic [4:0] c);
`ifdef SHIFT_UNIT_STEP4_EN
        return int'(c) / 4 + int'(c) % 4;
`else
        return int'(c);
`endif
    endfunction

    // Call at #1 after a rising edge with the DUT idle.
    task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] c,
                          input logic [1:0] o, input logic [31:0] expv, input bit poke);
        int n;
        data_in = d; shift_count = c; op = o; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; data_in = ~d; shift_count = ~c; op = ~o;
        if (c != 0) chk({name, " busy"}, {30'd0, busy, ready}, 32'd2);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            start = (poke && n == 1 && !done) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk({name, " latency"}, n, exp_latency(c));
        chk({name, " data"}, data_out, expv);
        @(posedge clk); #1;
        chk({name, " ready"}, {30'd0, ready, done}, 32'd2);
        chk({name, " hold"}, data_out, expv);
    endtask

    initial begin
        vecs[0]  = '{32'h12345678, 5'd4,  2'd0, 32'h23456780};
        vecs[1]  = '{32'h12345678, 5'd3,  2'd1, 32'h02468ACF};
        vecs[2]  = '{32'hF2345678, 5'd2,  2'd2, 32'hFC8D159E};
        vecs[3]  = '{32'hF2345678, 5'd1,  2'd3, 32'h791A2B3C};
        vecs[4]  = '{32'h80000001, 5'd31, 2'd3, 32'h00000003};
        vecs[5]  = '{32'hA5A5A5A5, 5'd0,  2'd0, 32'hA5A5A5A5};
        vecs[6]  = '{32'hA5A5A5A5, 5'd0,  2'd1, 32'hA5A5A5A5};
        vecs[7]  = '{32'hA5A5A5A5, 5'd0,  2'd2, 32'hA5A5A5A5};
        vecs[8]  = '{32'hA5A5A5A5, 5'd0,  2'd3, 32'hA5A5A5A5};
        vecs[9]  = '{32'h80000000, 5'd31, 2'd2, 32'hFFFFFFFF};
        vecs[10] = '{32'h00000001, 5'd31, 2'd0, 32'h80000000};
        vecs[11] = '{32'h80000000, 5'd31, 2'd1, 32'h00000001};
        vecs[12] = '{32'h12345678, 5'd8,  2'd3, 32'h78123456};
        vecs[13] = '{32'h7FFFFFFF, 5'd7,  2'd2, 32'h00FFFFFF};
        vecs[14] = '{32'h0000000F, 5'd6,  2'd0, 32'h000003C0};

        #12;
        chk("reset outputs", {ready, busy, done, 29'd0}, {3'b100, 29'd0});
        chk("reset data", data_out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].count,
                   vecs[i].opc, vecs[i].expv, 1'b0);
        end

        // start pulsed while shifting must be ignored
        run_op("poke", 32'h00000001, 5'd10, 2'd0, 32'h00000400, 1'b1);

        // reset right after E5 of a count-20 operation
        data_in = 32'hDEADBEEF; shift_count = 5'd20; op = 2'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset outputs", {ready, busy, done, 29'd0}, {3'b100, 29'd0});
        chk("midreset data", data_out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (30) begin
                @(posedge clk); #1;
                if (done) seen++;
            end
            chk("no stale done", seen, 0);
        end
        run_op("after reset", 32'h12345678, 5'd4, 2'd0, 32'h23456780, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
